// File: rtl/control_sequencer.sv
// Moore control sequencer for the single-bus 32-bit CPU: fetch/decode/execute
// one instruction at a time, driving datapath strobes from state and IR opcode.
module control_sequencer #(
    parameter int IR_WIDTH = 32,
    parameter int OPC_LSB  = 27
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [IR_WIDTH-1:0] IR,
    input  logic                mem_ready,
    input  logic                stop,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                Cout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                IncPC,
    output logic                Read,
    output logic                Write,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic [4:0]          alu_op,
    output logic                run
);

    typedef enum logic [3:0] {
        S_INIT, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, nxt;
    logic       armed;
    logic [4:0] opc;
    logic       is_rtype, is_addi, is_ldi, is_ld, is_st, is_halt;
    logic       is_mem, is_imm, is_exec;
    logic       unused_ir_bits;

    // IR is the instruction register output, so decoding it keeps outputs
    // a function of registered values only.
    assign opc            = IR[IR_WIDTH-1:OPC_LSB];
    assign unused_ir_bits = ^IR[OPC_LSB-1:0];

    assign is_rtype = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    assign is_addi  = (opc == OP_ADDI);
    assign is_ldi   = (opc == OP_LDI);
    assign is_ld    = (opc == OP_LD);
    assign is_st    = (opc == OP_ST);
    assign is_halt  = (opc == OP_HALT);
    assign is_mem   = is_ld || is_st;
    assign is_imm   = is_addi || is_ldi || is_mem;
    assign is_exec  = is_rtype || is_imm;

    // armed holds INIT for one edge after clear releases before fetching.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_INIT;
            armed <= 1'b0;
        end else begin
            state <= nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_INIT:       if (armed) nxt = S_T0;
            S_T0:         nxt = stop ? S_HALT : S_T1;
            S_T1, S_T1W:  nxt = mem_ready ? S_T2 : S_T1W;
            S_T2:         nxt = S_T3;
            S_T3:         nxt = is_halt ? S_HALT : (is_exec ? S_T4 : S_T0);
            S_T4:         nxt = S_T5;
            S_T5:         nxt = is_mem ? S_T6 : S_T0;
            S_T6:         if (is_st || mem_ready) nxt = S_T7;
            S_T7:         if (!is_st || mem_ready) nxt = S_T0;
            S_HALT:       nxt = S_HALT;
            default:      nxt = S_INIT;
        endcase
    end

    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout  = 1'b0;
        PCin  = 1'b0; MARin   = 1'b0; MDRin  = 1'b0; IRin  = 1'b0;
        Yin   = 1'b0; Zin     = 1'b0; IncPC  = 1'b0; Read  = 1'b0;
        Write = 1'b0; Gra     = 1'b0; Grb    = 1'b0; Grc   = 1'b0;
        Rin   = 1'b0; Rout    = 1'b0; BAout  = 1'b0;
        alu_op = 5'b00000;
        run    = (state != S_INIT) && (state != S_HALT);
        if (run) begin
            if (is_rtype)    alu_op = opc;
            else if (is_imm) alu_op = OP_ADD;
        end
        case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1, S_T1W: begin
                Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin    = (state == S_T1);
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: if (is_exec) begin
                Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                BAout = is_ldi || is_mem;
            end
            S_T4: begin
                if (is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1;
                end
            end
            S_T5: begin
                Zlowout = is_exec;
                if (is_mem) MARin = 1'b1;
                else if (is_exec) begin
                    Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Moore-style control unit for the single-bus 32-bit CPU.
- Fetches, decodes and executes one instruction at a time by driving register-file, bus-multiplexer, ALU and memory-interface control strobes.
- Drives the Gra/Grb/Grc/Rin/Rout/BAout register-select interface. The register-file select logic expands these into per-register R*in/R*out enables; R0 reads as zero when BAout is high.
- Sits between the instruction register and the datapath; memory accesses use a ready handshake.

Parameters:
IR_WIDTH, 32, instruction register width
OPC_LSB, 27, bit position of opcode LSB (opcode = IR[IR_WIDTH-1:OPC_LSB], 5 bits)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-low reset
IR  in  IR_WIDTH  current instruction register contents
mem_ready  in  1  memory completed the current Read/Write
stop  in  1  request halt at next instruction boundary
PCout, Zlowout, MDRout, Cout  out  1 each  bus drive enables
PCin, MARin, MDRin, IRin, Yin, Zin  out  1 each  register load enables
IncPC  out  1  ALU computes PC+1 instead of alu_op
Read, Write  out  1 each  memory strobes
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/enable
alu_op  out  5  ALU operation code
run  out  1  high while executing; low in INIT/HALT

Behaviour:
- All outputs are a pure decode of the registered state and the registered IR opcode; no combinational path from mem_ready/stop to outputs.
- clear low (any time, including mid-memory access): state := INIT immediately; every output 0.
- INIT: outputs 0, run=0; next edge -> T0.
- Fetch (run=1 from T0 on):
  - T0: PCout, MARin, IncPC, Zin. If stop=1 on this edge -> HALT instead of T1.
  - T1: Zlowout, PCin, Read, MDRin. Stays in T1 while mem_ready=0 (PCin only pulses on first T1 cycle); -> T2 on edge where mem_ready=1.
  - T2: MDRout, IRin -> T3 (or T0 for nop/illegal, HALT for halt, decided on IR after load, i.e. in T3 decode).
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, nop 11010, halt 11011; all others = illegal, treated as nop.
- alu_op = opcode for add/sub/and/or; 00011 (add) for ld/ldi/st/addi; 00000 otherwise.
- R-type (add/sub/and/or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin (alu_op valid).
  - T5: Zlowout, Gra, Rin -> T0.
- addi: T3 Grb, Rout, Yin; T4 Cout, Zin; T5 Zlowout, Gra, Rin -> T0.
- ldi: as addi but BAout asserted with Rout in T3.
- ld:
  - T3: Grb, Rout, BAout, Yin.
  - T4: Cout, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; held until mem_ready=1.
  - T7: MDRout, Gra, Rin -> T0.
- st:
  - T3-T5 as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write; held until mem_ready=1 -> T0.
- nop/illegal: T3 outputs 0 -> T0. halt: T3 -> HALT.
- HALT: outputs 0, run=0; exits only via clear.
- mem_ready high outside T1/T6(ld)/T7(st) is ignored.
- stop is sampled only in T0.
- At most one bus-drive enable (PCout, Zlowout, MDRout, Cout, Rout) is high in any state.

Test Plan:
- Reset: hold clear=0 three cycles, assert mid-T1 with Read=1 -> all outputs 0 asynchronously; first edge after release -> INIT, next -> T0 with PCout=MARin=IncPC=Zin=1.
- add with IR=0x18000000|{Ra=2,Rb=3,Rc=4}, mem_ready=1 always -> states T0,T1,T2,T3,T4,T5,T0 (6 cycles/instruction); alu_op=00011 in T4; Grc=Rout=Zin=1 in T4.
- ld with mem_ready delayed 3 cycles in T6 -> Read=MDRin=1 held exactly 4 cycles; BAout=1 only in T3; T7 asserts MDRout, Gra, Rin.
- st with mem_ready=0 for 2 cycles in T7 -> Write high 3 cycles, then T0; Gra=Rout=MDRin=1 in T6.
- halt opcode 11011 -> after T3, run=0 and all outputs 0 indefinitely, even with stop/mem_ready toggling; clear pulse restarts at INIT.
- stop=1 during T3 of add -> instruction completes; stop still 1 at T0 -> HALT, no Read asserted.
